oflow_mem_read_sequencer: RTL and testbench

OFLOW_MEM_READ_SEQUENCER -- requirements
Module: oflow_mem_read_sequencer

---
 rtl/oflow_mem_read_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_oflow_mem_read_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_mem_read_sequencer.sv
// Read sequencer for the optical-flow history buffer: issues line reads, re-times the
// returning data through a small FWFT line buffer and tags each line with frame/bbox indices.
//
// state | meaning
// IDLE  | waiting for start, buffer in write mode
// ISSUE | issuing read requests while buffer space allows
// DRAIN | all requests issued, waiting for the last line to be consumed
// DONE  | one-cycle completion pulse
module oflow_mem_read_sequencer #(
    parameter int DATA_WIDTH                  = 64,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
    parameter int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6,
    parameter int READ_LATENCY                = 2,
    parameter int FIFO_DEPTH                  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame,
    input  logic [DATA_WIDTH-1:0]                  mem_data_0,
    output logic                                   rnw_st,
    output logic                                   start_read,
    output logic                                   read_new_line,
    output logic [DATA_WIDTH-1:0]                  line_data,
    output logic                                   line_valid,
    input  logic                                   line_ready,
    output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] line_frame_idx,
    output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  line_bbox_idx,
    output logic                                   line_last,
    output logic                                   done
);

    localparam int FW = NUM_OF_HISTORY_FRAMES_WIDTH;
    localparam int BW = NUM_OF_BBOX_IN_FRAME_WIDTH;
    localparam int TW = FW + BW;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t                  r_state;
    logic                    r_rnw;
    logic                    r_start_read;
    logic                    r_read_new_line;
    logic                    r_done;
    logic [TW-1:0]           r_total;
    logic [TW-1:0]           r_issued;
    logic [TW-1:0]           r_popped;
    logic [BW-1:0]           r_bbox;
    logic [FW-1:0]           r_frame_idx;
    logic [BW-1:0]           r_bbox_idx;
    logic [READ_LATENCY-1:0] r_pipe;
    logic [CW-1:0]           r_inflight;
    logic [CW-1:0]           r_count;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_req;
    logic          w_issue;
    logic          w_last_pop;
    logic          w_drain_done;
    logic [CW:0]   w_occ;
    logic [TW-1:0] w_total;
    logic [TW-1:0] w_total_m1;

    assign w_total      = TW'(num_of_history_frames) * TW'(num_of_bbox_in_frame);
    assign w_total_m1   = r_total - TW'(1);
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && line_ready;
    assign w_push       = r_pipe[READ_LATENCY-1];
    assign w_req        = r_start_read | r_read_new_line;
    // inflight already counts the request being registered this cycle, so the
    // occupancy bound can never be overrun by data still in the read pipeline
    assign w_occ        = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue      = (r_state == ST_ISSUE) && (r_issued < r_total) && (w_occ < DEPTH_W);
    assign w_last_pop   = w_pop && (r_popped == w_total_m1);
    assign w_drain_done = (r_inflight == '0) && (w_last_pop || (r_popped == r_total));

    assign rnw_st         = r_rnw;
    assign start_read     = r_start_read;
    assign read_new_line  = r_read_new_line;
    assign done           = r_done;
    assign line_valid     = w_valid;
    assign line_data      = w_valid ? r_mem[r_rd_ptr] : '0;
    assign line_frame_idx = r_frame_idx;
    assign line_bbox_idx  = r_bbox_idx;
    assign line_last      = w_valid && (r_popped == w_total_m1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem_data_0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_N || abort) begin
            r_state         <= ST_IDLE;
            r_rnw           <= 1'b0;
            r_start_read    <= 1'b0;
            r_read_new_line <= 1'b0;
            r_done          <= 1'b0;
            r_total         <= '0;
            r_issued        <= '0;
            r_popped        <= '0;
            r_bbox          <= '0;
            r_frame_idx     <= '0;
            r_bbox_idx      <= '0;
            r_pipe          <= '0;
            r_inflight      <= '0;
            r_count         <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
        end else begin
            r_start_read    <= 1'b0;
            r_read_new_line <= 1'b0;
            r_done          <= 1'b0;

            r_pipe[0] <= w_req;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_popped <= r_popped + TW'(1);
                if (r_bbox_idx == r_bbox - BW'(1)) begin
                    r_bbox_idx  <= '0;
                    r_frame_idx <= r_frame_idx + FW'(1);
                end else begin
                    r_bbox_idx  <= r_bbox_idx + BW'(1);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_total     <= w_total;
                        r_bbox      <= num_of_bbox_in_frame;
                        r_issued    <= '0;
                        r_popped    <= '0;
                        r_frame_idx <= '0;
                        r_bbox_idx  <= '0;
                        r_rnw       <= 1'b1;
                        if (w_total == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_issued        <= r_issued + TW'(1);
                        r_start_read    <= (r_issued == '0);
                        r_read_new_line <= (r_issued != '0);
                        if (r_issued == w_total_m1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_rnw   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rnw   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oflow_mem_read_sequencer.sv
// Directed bench for oflow_mem_read_sequencer: a latency-2 memory model tags each read
// with its request number, and a monitor checks line order, indices, last and done timing.
module tb_oflow_mem_read_sequencer;

    localparam int DW    = 64;
    localparam int FW    = 3;
    localparam int BW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_N;
    logic          start;
    logic          abort;
    logic [FW-1:0] num_of_history_frames;
    logic [BW-1:0] num_of_bbox_in_frame;
    logic [DW-1:0] mem_data_0;
    logic          rnw_st;
    logic          start_read;
    logic          read_new_line;
    logic [DW-1:0] line_data;
    logic          line_valid;
    logic          line_ready;
    logic [FW-1:0] line_frame_idx;
    logic [BW-1:0] line_bbox_idx;
    logic          line_last;
    logic          done;

    oflow_mem_read_sequencer #(
        .DATA_WIDTH(DW), .NUM_OF_HISTORY_FRAMES_WIDTH(FW), .NUM_OF_BBOX_IN_FRAME_WIDTH(BW),
        .READ_LATENCY(2), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_N(reset_N), .start(start), .abort(abort),
        .num_of_history_frames(num_of_history_frames), .num_of_bbox_in_frame(num_of_bbox_in_frame),
        .mem_data_0(mem_data_0), .rnw_st(rnw_st), .start_read(start_read),
        .read_new_line(read_new_line), .line_data(line_data), .line_valid(line_valid),
        .line_ready(line_ready), .line_frame_idx(line_frame_idx), .line_bbox_idx(line_bbox_idx),
        .line_last(line_last), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] tag(input int n);
        return 64'hC0DE_0000_0000_0000 | DW'(n);
    endfunction

    // written only by the stimulus process
    int pass_seq = 0;
    int exp_total = 0;
    int exp_bbox = 0;
    int start_cyc = 0;

    // written only by the monitor
    int seen_seq = 0;
    int req_n = 0, sr_cnt = 0, nl_cnt = 0, both_cnt = 0, rnw_cnt = 0;
    int done_cnt = 0, done_cyc = 0, last_cyc = 0, line_n = 0;
    logic [DW-1:0] pipe0 = '1, pipe1 = '1;
    logic          hold_prev = 1'b0;
    logic [DW+FW+BW:0] hold_val = '0;

    always @(negedge clk) begin
        if (seen_seq != pass_seq) begin
            seen_seq = pass_seq;
            req_n = 0; sr_cnt = 0; nl_cnt = 0; both_cnt = 0; rnw_cnt = 0;
            done_cnt = 0; done_cyc = 0; last_cyc = 0; line_n = 0;
        end
        // data for a request seen in cycle k is presented throughout cycle k+2
        mem_data_0 = pipe1;
        pipe1 = pipe0;
        pipe0 = (start_read || read_new_line) ? tag(req_n) : 64'hDEAD_BEEF_DEAD_BEEF;
        if (start_read || read_new_line) req_n++;
        if (start_read) sr_cnt++;
        if (read_new_line) nl_cnt++;
        if (start_read && read_new_line) both_cnt++;
        if (rnw_st) rnw_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold_prev && line_valid)
            chk("hold", {line_data, line_frame_idx, line_bbox_idx, line_last}, hold_val);
        hold_prev = line_valid && !line_ready;
        hold_val = {line_data, line_frame_idx, line_bbox_idx, line_last};
        if (line_valid && line_ready) begin
            if (exp_bbox == 0) begin
                chk("unexpected_line", line_n, exp_total);
            end else begin
                chk("line", {line_data, line_frame_idx, line_bbox_idx, line_last},
                    {tag(line_n), FW'(line_n / exp_bbox), BW'(line_n % exp_bbox),
                     (line_n == exp_total - 1)});
            end
            if (line_n == exp_total - 1) last_cyc = cyc;
            line_n++;
        end
    end

    typedef struct {
        int frames;
        int bbox;
        int stall;
        int exp_stall_req;
        bit restart;
    } vec_t;

    task automatic begin_pass(input int fr, input int bb, input bit rdy);
        @(posedge clk); #1;
        exp_total = fr * bb;
        exp_bbox = bb;
        pass_seq++;
        num_of_history_frames = FW'(fr);
        num_of_bbox_in_frame = BW'(bb);
        line_ready = rdy;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input vec_t v);
        int total;
        int tmo;
        total = v.frames * v.bbox;
        begin_pass(v.frames, v.bbox, v.stall == 0);
        if (v.restart) begin
            @(posedge clk); #1;
            num_of_history_frames = 3'd7;
            num_of_bbox_in_frame = 6'd7;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (v.stall > 0) begin
            repeat (v.stall - 1) @(posedge clk);
            #1;
            chk("stall_req", sr_cnt + nl_cnt, v.exp_stall_req);
            chk("stall_lines", line_n, 0);
            chk("stall_valid", line_valid, 1'b1);
            line_ready = 1'b1;
        end
        tmo = 0;
        while (done_cnt == 0 && tmo < 3000) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("done_seen", done_cnt != 0, 1'b1);
        @(posedge clk); #1;
        chk("lines", line_n, total);
        chk("start_read_cnt", sr_cnt, (total > 0) ? 1 : 0);
        chk("read_new_line_cnt", nl_cnt, (total > 0) ? total - 1 : 0);
        chk("both_req", both_cnt, 0);
        chk("done_once", done_cnt, 1);
        chk("done_time", done_cyc, (total > 0) ? last_cyc + 1 : start_cyc + 1);
        chk("rnw_cycles", rnw_cnt, done_cyc - start_cyc);
        chk("idle_rnw", rnw_st, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, {rnw_st, start_read, read_new_line, line_valid, line_last, done,
                   line_data, line_frame_idx, line_bbox_idx}, '0);
    endtask

    initial begin
        vec_t vecs[7];
        int tmo;
        vecs[0] = '{2, 3, 0, 0, 1'b0};
        vecs[1] = '{3, 4, 20, DEPTH, 1'b0};
        vecs[2] = '{0, 5, 0, 0, 1'b0};
        vecs[3] = '{1, 1, 0, 0, 1'b0};
        vecs[4] = '{7, 63, 0, 0, 1'b0};
        vecs[5] = '{5, 0, 0, 0, 1'b0};
        vecs[6] = '{2, 5, 8, DEPTH, 1'b0};

        reset_N = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        line_ready = 1'b0;
        num_of_history_frames = '0;
        num_of_bbox_in_frame = '0;
        mem_data_0 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset_outputs");
        reset_N = 1'b1;

        for (int i = 0; i < 7; i++) run_pass(vecs[i]);

        // abort after the 10th transfer of a long pass
        begin_pass(4, 63, 1'b1);
        tmo = 0;
        while (line_n < 10 && tmo < 500) begin
            @(posedge clk); #1;
            tmo++;
        end
        abort = 1'b1;
        line_ready = 1'b0;
        chk("abort_lines", line_n, 10);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {rnw_st, line_valid, line_last, start_read, read_new_line, done}, '0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        run_pass('{4, 63, 0, 0, 1'b0});

        // reset while draining, then a second start during ISSUE must be ignored
        begin_pass(1, 3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("drain_valid", line_valid, 1'b1);
        reset_N = 1'b0;
        @(posedge clk); #1;
        chk_outputs_zero("midpass_reset");
        reset_N = 1'b1;
        repeat (4) @(posedge clk);
        run_pass('{2, 3, 0, 0, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
